// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access-size codes,
// FSM state encoding, byte-enable lane constants, captured-request payload
// and the alignment rule.
package mem_stage_lsu_pkg;

    // Access size encodings as carried on req_size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Byte-enable patterns; bit 3 is the most significant lane (addr offset 0).
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_ALL     = 4'b1111;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_BYTE0   = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } lsu_state_e;

    // Request fields held for the duration of an access.
    typedef struct packed {
        logic       rw;
        logic [1:0] size;
        logic       se;
        logic [1:0] lane;
        logic [4:0] rd;
    } lsu_req_t;

    // Natural alignment check; the reserved size is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b1;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Combinational big-endian lane formatter.
// Store side: replicates store data across lanes and builds byte enables.
// Load side: extracts the addressed byte/halfword and sign- or zero-extends.
// Ports:
//   st_size, st_lane, st_wdata  store request (size, addr[1:0], right-justified data)
//   st_data_c, st_be_c          lane-steered store data and byte enables
//   ld_size, ld_lane, ld_se     load request (size, addr[1:0], sign-extend)
//   ld_rdata                    raw memory word
//   ld_data_c                   formatted load result
module lsu_lane_fmt
    import mem_stage_lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_data_c,
    output logic [3:0]  st_be_c,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic        ld_se,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store steering: narrow data is replicated so any enabled lane sees it.
    always_comb begin
        st_data_c = '0;
        st_be_c   = BE_NONE;
        case (st_size)
            SZ_BYTE: begin
                st_data_c = {4{st_wdata[7:0]}};
                st_be_c   = BE_BYTE0 >> st_lane;
            end
            SZ_HALF: begin
                st_data_c = {2{st_wdata[15:0]}};
                st_be_c   = st_lane[1] ? BE_LO_HALF : BE_HI_HALF;
            end
            SZ_WORD: begin
                st_data_c = st_wdata;
                st_be_c   = BE_ALL;
            end
            default: ;
        endcase
    end

    // Load lane selection: offset 0 lives in the most significant byte.
    always_comb begin
        byte_sel = ld_rdata[31:24];
        case (ld_lane)
            2'd0:    byte_sel = ld_rdata[31:24];
            2'd1:    byte_sel = ld_rdata[23:16];
            2'd2:    byte_sel = ld_rdata[15:8];
            default: byte_sel = ld_rdata[7:0];
        endcase
        half_sel = ld_lane[1] ? ld_rdata[15:0] : ld_rdata[31:16];
    end

    // Load extension.
    always_comb begin
        ld_data_c = '0;
        case (ld_size)
            SZ_BYTE: ld_data_c = ld_se ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
            SZ_HALF: ld_data_c = ld_se ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
            SZ_WORD: ld_data_c = ld_rdata;
            default: ld_data_c = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit with a request/acknowledge data-memory port.
// Stalls the pipeline while an access is outstanding, flags misaligned
// requests, and declares a bus error if the memory does not acknowledge
// within TIMEOUT_CYC cycles.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   req_*                       memory instruction from EX/MEM
//   stall                       freeze upstream pipeline registers
//   mem_req/we/addr/be/wdata    data-memory request (held until ack)
//   mem_ack, mem_rdata          data-memory completion and read word
//   ld_valid, ld_data, ld_rd    load result for MEM/WB (one-cycle pulse)
//   mis_align, bus_err          one-cycle fault pulses
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_rw,
    input  logic [1:0]        req_size,
    input  logic              req_se,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic [4:0]        ld_rd,
    output logic              mis_align,
    output logic              bus_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e       state_q;
    lsu_state_e       state_d;
    lsu_req_t         req_q;
    logic [CNT_W-1:0] cnt_q;
    logic             capture;
    logic             finish;
    logic [31:0]      st_data_c;
    logic [3:0]       st_be_c;
    logic [31:0]      ld_fmt_c;
    logic             unused_addr_hi;

    // Address bits above the RAM window are not decoded.
    assign unused_addr_hi = ^req_addr[31:ADDR_W];

    lsu_lane_fmt u_fmt (
        .st_size   (req_size),
        .st_lane   (req_addr[1:0]),
        .st_wdata  (req_wdata),
        .st_data_c (st_data_c),
        .st_be_c   (st_be_c),
        .ld_size   (req_q.size),
        .ld_lane   (req_q.lane),
        .ld_se     (req_q.se),
        .ld_rdata  (mem_rdata),
        .ld_data_c (ld_fmt_c)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and combinational pulses. While reset is held the flags stay
    // low even if EX/MEM is still presenting a request.
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        mis_align = 1'b0;
        bus_err   = 1'b0;
        capture   = 1'b0;
        finish    = 1'b0;
        if (reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            mis_align = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            capture = 1'b1;
                            state_d = ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    stall = 1'b1;
                    // An ack in the timeout cycle still counts as a completion.
                    if (mem_ack) begin
                        finish  = 1'b1;
                        state_d = ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        bus_err = 1'b1;
                        finish  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Captured request, memory port, timeout counter and load result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= BE_NONE;
            mem_wdata <= '0;
            cnt_q     <= '0;
            ld_valid  <= 1'b0;
            ld_data   <= '0;
            ld_rd     <= '0;
        end else begin
            if (capture) begin
                req_q.rw   <= req_rw;
                req_q.size <= req_size;
                req_q.se   <= req_se;
                req_q.lane <= req_addr[1:0];
                req_q.rd   <= req_rd;
                mem_req    <= 1'b1;
                mem_we     <= req_rw;
                mem_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
                mem_be     <= req_rw ? st_be_c : BE_ALL;
                mem_wdata  <= req_rw ? st_data_c : 32'h0;
            end else if (finish) begin
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_be    <= BE_NONE;
                mem_wdata <= '0;
            end

            cnt_q <= ((state_q == ST_ISSUE) && !finish) ? cnt_q + CNT_W'(1) : '0;

            ld_valid <= finish && !req_q.rw;
            if (finish && !req_q.rw) begin
                ld_data <= mem_ack ? ld_fmt_c : 32'h0;
                ld_rd   <= req_q.rd;
            end
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage. It sits directly downstream of the EX/MEM pipeline register and upstream of MEM/WB.
- Replaces the single-cycle combinational data-RAM hookup with a request/acknowledge data-memory port. This makes the pipeline tolerate multi-cycle memories.
- Performs SPARC big-endian byte-lane steering, sign/zero extension, misalignment detection and a bus timeout.
- Stalls the whole pipeline while an access is outstanding.

Parameters:
- ADDR_W, 9, data-memory byte-address width (matches the existing 512-byte RAM).
- TIMEOUT_CYC, 16, cycles in ISSUE without mem_ack before a bus error is declared (must be >= 2).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  EX/MEM holds a memory instruction (E_MEM).
- req_rw  in  1  1 = store, 0 = load (RW_MEM encoding).
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- req_se  in  1  sign-extend on load.
- req_addr  in  32  effective address (ALU_OUT_MEM).
- req_wdata  in  32  store data, right-justified.
- req_rd  in  5  destination register of a load.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- mem_req  out  1  memory request strobe.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- mem_be  out  4  byte enables; be[3] = bits 31:24.
- mem_wdata  out  32  lane-steered store data.
- mem_ack  in  1  memory completion; rdata valid in the same cycle.
- mem_rdata  in  32  read word.
- ld_valid  out  1  one-cycle pulse: ld_data/ld_rd valid for MEM/WB.
- ld_data  out  32  formatted load result.
- ld_rd  out  5  load destination.
- mis_align  out  1  one-cycle misalignment fault pulse.
- bus_err  out  1  one-cycle timeout fault pulse.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; timeout counter = 0.
  - All outputs 0: mem_req, mem_we, mem_be, mem_addr, mem_wdata, ld_*, stall, mis_align, bus_err.
  - Reset mid-access drops mem_req immediately. A late mem_ack is ignored.
- Misalignment, evaluated combinationally in IDLE:
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0;
  - size = 11 always.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - req_valid and aligned: stall = 1 (combinational). Capture rw, size, se, addr, wdata, rd into internal registers; go to ISSUE.
  - req_valid and misaligned: mis_align = 1 for that cycle, stall = 0, no memory access, stay in IDLE.
  - no req_valid: stall = 0.
- ISSUE:
  - stall = 1 and mem_req = 1. mem_we, mem_addr, mem_be and mem_wdata are driven from the captured registers and held stable until ack.
  - The counter increments each cycle.
  - mem_ack = 1: register the formatted load data, go to DONE.
  - Counter reaches TIMEOUT_CYC - 1 without ack: bus_err = 1 that cycle, load data = 0, go to DONE.
  - mem_ack and timeout in the same cycle: ack wins, no bus_err.
- DONE:
  - stall = 0, so the pipeline advances on this edge.
  - ld_valid = 1 only for loads (also on a bus error, with data 0).
  - Counter cleared; return to IDLE.
  - req_valid is ignored in DONE; that request is the one just completed.
- Load latency: minimum 3 cycles (IDLE to DONE with ack on the first ISSUE cycle). stall is high for exactly 2 of those cycles.
- Byte lanes (big-endian):
  - byte at addr[1:0] = k is read from bits [31-8k -: 8]; halfword at addr[1] = h from [31-16h -: 16].
  - Store: byte replicated to all 4 lanes with one-hot be; halfword replicated to both halves with be 1100/0011; word be = 1111.
  - Load: mem_be = 1111; extract the lane, then sign-extend if se = 1, otherwise zero-extend.

Decomposition:
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, lane-select helper constants.
- One natural sub-module, lsu_lane_fmt: purely combinational store steering/byte-enable generation and load extract/extend. It keeps the FSM file focused on sequencing.

Test Plan:
- Word store, addr 0x004, wdata 0xDEADBEEF, mem_ack on first ISSUE cycle:
  - mem_be = 1111, mem_addr = 0x004, mem_wdata = 0xDEADBEEF;
  - stall high 2 cycles; ld_valid stays 0.
- Byte load, signed, addr 0x003, rdata 0x112233F0 → ld_data = 0xFFFFFFF0. Same load unsigned → 0x000000F0. ld_rd is echoed.
- Halfword store, addr 0x002, wdata 0x0000ABCD → mem_be = 0011, mem_wdata = 0xABCDABCD.
- Halfword load, addr 0x001 → mis_align pulse, no mem_req, stall = 0. Same for word at 0x002 and for size 11.
- mem_ack never asserted, TIMEOUT_CYC = 16:
  - bus_err pulses in the 16th ISSUE cycle;
  - load completes with ld_data = 0; stall is released in DONE.
- reset asserted during ISSUE after 3 wait cycles → all outputs 0 asynchronously. A subsequent stray mem_ack produces no ld_valid.
